ufp_mul_pipe: RTL and testbench

//   Pipelined unsigned fixed-point multiplier, UQ(IW).(QW) x UQ(IW).(QW) -> UQ(IW).(QW).

---
 rtl/ufp_mul_pipe_if.sv | 7 +
 rtl/ufp_mul_pipe.sv | 55 +++++
 tb/tb_ufp_mul_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ufp_mul_pipe_if.sv
// ufp_mul_pipe_if: operand/result valid-ready bundle for ufp_mul_pipe
interface ufp_mul_pipe_if #(parameter int W = 32);
  logic in_valid, in_ready, clip, out_valid, out_ready, clipping;
  logic [W-1:0] x, y, out_data;
  modport master (output in_valid, x, y, clip, out_ready, input in_ready, out_valid, out_data, clipping);
  modport slave (input in_valid, x, y, clip, out_ready, output in_ready, out_valid, out_data, clipping);
endinterface

// File: rtl/ufp_mul_pipe.sv
// ufp_mul_pipe: pipelined UQ(IW).(QW) multiplier with valid/ready backpressure, clip/wrap and optional rounding
module ufp_mul_pipe #(
  parameter int IW = 16,
  parameter int QW = 16,
  parameter int STAGES = 3,
  parameter int ROUND = 0
) (
  input logic clk,
  input logic rst,
  ufp_mul_pipe_if.slave bus
);
  localparam int W = IW + QW;
  localparam logic [2*W:0] RND = (ROUND != 0) ? ((2*W+1)'(1) << (QW - 1)) : '0;
  logic [2*W-QW:0] s;
  logic ovf, stall;
  logic [W-1:0] res;
  logic [STAGES-1:0] vld_q, vld_d, ovf_q, ovf_d;
  logic [STAGES-1:0][W-1:0] dat_q, dat_d;
  // Whole result is formed at the input; the remaining stages only delay it.
  always_comb begin
    s = (2*W-QW+1)'(((2*W+1)'(bus.x) * (2*W+1)'(bus.y) + RND) >> QW);
    ovf = |s[2*W-QW:W];
    res = (ovf && bus.clip) ? '1 : s[W-1:0];
  end
  assign stall = vld_q[STAGES-1] && !bus.out_ready;
  always_comb begin
    vld_d = vld_q;
    ovf_d = ovf_q;
    dat_d = dat_q;
    if (!stall) begin
      vld_d[0] = bus.in_valid;
      ovf_d[0] = ovf;
      dat_d[0] = res;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        ovf_d[i] = ovf_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      ovf_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      dat_q <= dat_d;
    end
  assign bus.in_ready = !stall;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_data = dat_q[STAGES-1];
  assign bus.clipping = ovf_q[STAGES-1];
endmodule

// File: tb/tb_ufp_mul_pipe.sv
// tb_ufp_mul_pipe: vector table, scoreboard and directed stall/reset sequences for ufp_mul_pipe
module tb_ufp_mul_pipe;
  localparam int ST = 3;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  ufp_mul_pipe_if #(.W(32)) b0 ();
  ufp_mul_pipe_if #(.W(32)) b1 ();
  ufp_mul_pipe #(.IW(16), .QW(16), .STAGES(ST), .ROUND(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  ufp_mul_pipe #(.IW(16), .QW(16), .STAGES(1), .ROUND(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {
    logic [31:0] x, y;
    logic clip;
    logic [31:0] d;
    logic o;
  } vec_t;
  vec_t tv [14];
  logic [32:0] sb [$];
  int nchk = 0, nerr = 0, ndel = 0, nacc = 0, cyc = 0, c0, k;
  logic [31:0] hd;
  logic hc, stable, stale, pend;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic c, input logic rnd);
    logic [64:0] r;
    logic [48:0] s;
    r = 65'(a) * 65'(b) + (rnd ? 65'h8000 : 65'h0);
    s = r[64:16];
    return {|s[48:32], (|s[48:32] && c) ? 32'hFFFFFFFF : s[31:0]};
  endfunction
  always @(negedge clk)
    if (!rst && b0.out_valid && b0.out_ready) begin
      ndel++;
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_out: got %h want no result", {b0.clipping, b0.out_data});
      end else chk("sb_out", {b0.clipping, b0.out_data}, sb.pop_front());
    end
  task automatic send(input logic [31:0] xx, input logic [31:0] yy, input logic c, input logic [32:0] e);
    bit ok = 0;
    b0.x = xx;
    b0.y = yy;
    b0.clip = c;
    b0.in_valid = 1;
    for (int j = 0; j < 1000 && !ok; j++) begin
      @(negedge clk);
      if (b0.in_ready) begin
        sb.push_back(e);
        nacc++;
        ok = 1;
      end
    end
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: in_ready=0 want 1");
    end
    @(posedge clk);
    #1 b0.in_valid = 0;
  endtask
  task automatic drain();
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (sb.size() == 0 && !b0.out_valid) break;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rchk(input string n, input logic [31:0] xx, input logic [31:0] yy, input logic [32:0] e);
    b1.x = xx;
    b1.y = yy;
    b1.clip = 0;
    b1.in_valid = 1;
    @(posedge clk);
    #1 b1.in_valid = 0;
    chk({n, "_valid"}, b1.out_valid, 1);
    chk(n, {b1.clipping, b1.out_data}, e);
  endtask
  initial begin
    tv[0]  = '{32'h00020000, 32'h00030000, 0, 32'h00060000, 0};
    tv[1]  = '{32'h80000000, 32'h00020000, 1, 32'hFFFFFFFF, 1};
    tv[2]  = '{32'h80000000, 32'h00020000, 0, 32'h00000000, 1};
    tv[3]  = '{32'h00000001, 32'h00008000, 0, 32'h00000000, 0};
    tv[4]  = '{32'h00000000, 32'hFFFFFFFF, 1, 32'h00000000, 0};
    tv[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1};
    tv[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFE0000, 1};
    tv[7]  = '{32'h00010000, 32'h00010000, 0, 32'h00010000, 0};
    tv[8]  = '{32'h00018000, 32'h00028000, 1, 32'h0003C000, 0};
    tv[9]  = '{32'hFFFFFFFF, 32'h00010000, 0, 32'hFFFFFFFF, 0};
    tv[10] = '{32'h00010000, 32'hFFFF0000, 1, 32'hFFFF0000, 0};
    tv[11] = '{32'h00020000, 32'h80000000, 0, 32'h00000000, 1};
    tv[12] = '{32'h0000C000, 32'h0000C000, 0, 32'h00009000, 0};
    tv[13] = '{32'h00000003, 32'h00005555, 0, 32'h00000000, 0};
    b0.in_valid = 0; b0.x = 0; b0.y = 0; b0.clip = 0; b0.out_ready = 1;
    b1.in_valid = 0; b1.x = 0; b1.y = 0; b1.clip = 0; b1.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out", {b0.clipping, b0.out_data}, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    rst = 0;
    ndel = 0;
    c0 = cyc;
    for (int i = 0; i < 14; i++) send(tv[i].x, tv[i].y, tv[i].clip, {tv[i].o, tv[i].d});
    chk("throughput", cyc - c0, 14);
    drain();
    chk("table_count", ndel, 14);
    send(32'h00020000, 32'h00030000, 0, {1'b0, 32'h00060000});
    c0 = cyc;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b0.out_valid) break;
    end
    chk("latency", cyc - c0, ST - 1);
    chk("latency_data", {b0.clipping, b0.out_data}, {1'b0, 32'h00060000});
    drain();
    rchk("rnd_half", 32'h00000001, 32'h00008000, {1'b0, 32'h00000001});
    rchk("rnd_max", 32'hFFFFFFFF, 32'h00010000, {1'b0, 32'hFFFFFFFF});
    rchk("rnd_up", 32'h00000003, 32'h00005555, {1'b0, 32'h00000001});
    rchk("rnd_int", 32'h00020000, 32'h00030000, {1'b0, 32'h00060000});
    ndel = 0;
    fork
      for (int i = 0; i < 10; i++)
        send(32'((i + 1) << 17), 32'hC0000000 >> i, i[0], model(32'((i + 1) << 17), 32'hC0000000 >> i, i[0], 0));
      begin
        for (int j = 0; j < 50; j++) begin
          @(negedge clk);
          if (b0.out_valid) break;
        end
        @(posedge clk);
        #1 b0.out_ready = 0;
        @(negedge clk);
        hd = b0.out_data;
        hc = b0.clipping;
        stable = 1;
        chk("stall_in_ready", b0.in_ready, 0);
        repeat (8) begin
          @(negedge clk);
          stable &= b0.out_valid && !b0.in_ready && b0.out_data == hd && b0.clipping == hc;
        end
        chk("stall_stable", stable, 1);
        @(posedge clk);
        #1 b0.out_ready = 1;
      end
    join
    drain();
    chk("stall_count", ndel, 10);
    chk("stall_sb_empty", sb.size(), 0);
    ndel = 0;
    nacc = 0;
    pend = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (!pend) begin
        b0.in_valid = $urandom_range(0, 3) != 0;
        b0.x = $urandom >> $urandom_range(0, 31);
        b0.y = $urandom >> $urandom_range(0, 31);
        b0.clip = 1'($urandom);
      end
      b0.out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (b0.in_valid && b0.in_ready) begin
        sb.push_back(model(b0.x, b0.y, b0.clip, 0));
        nacc++;
        pend = 0;
      end else pend = b0.in_valid;
    end
    @(posedge clk);
    #1 b0.in_valid = 0;
    b0.out_ready = 1;
    drain();
    chk("rand_count", ndel, nacc);
    chk("rand_sb_empty", sb.size(), 0);
    send(32'h00050000, 32'h00020000, 0, {1'b0, 32'h000A0000});
    send(32'h80000000, 32'h00040000, 1, {1'b1, 32'hFFFFFFFF});
    @(posedge clk);
    #2;
    chk("pre_rst_valid", b0.out_valid, 1);
    rst = 1;
    #1;
    chk("async_rst_valid", b0.out_valid, 0);
    chk("async_rst_out", {b0.clipping, b0.out_data}, 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    ndel = 0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      stale |= b0.out_valid;
    end
    chk("no_stale", stale, 0);
    @(posedge clk);
    #1;
    send(32'h00030000, 32'h00030000, 1, {1'b0, 32'h00090000});
    drain();
    chk("post_rst_count", ndel, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
